// File: rtl/fifomult2024_arbiter.sv
// fifomult2024_arbiter
// Round-robin arbiter/sequencer sharing one fifomult2024 multiplier between
// N_REQ requesters. One operation in flight: grant, two serial operand beats
// (A, gap, B), wait for the result or a timeout, then a one-cycle response
// pulse to the owner.
//
// Beat timing: every output toward the multiplier is a flop. The beat for a
// SEND state is loaded on the edge entering (or re-entering) that state,
// using mul_busy_out sampled in the cycle before. So the cycle in which
// mul_data_in_valid is high is the SEND_A/SEND_B cycle itself, and each
// sampled busy cycle pushes the beat out by one cycle.
module fifomult2024_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_a_parity_err,
  input  logic [N_REQ-1:0]      req_b_parity_err,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_parity,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [15:0]           mul_data_in,
  output logic                  mul_data_in_parity,
  output logic                  mul_data_in_valid,
  input  logic                  mul_busy_out,
  input  logic [31:0]           mul_data_out,
  input  logic                  mul_data_out_parity,
  input  logic                  mul_data_out_valid,
  input  logic                  mul_data_in_parity_error
);

  localparam int LW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_GAP, S_SEND_B, S_WAIT_RES, S_RESP
  } state_t;

  state_t                    state, nstate;
  logic [LW-1:0]             last_grant;   // also the owner of the op in flight
  logic [LW-1:0]             gnt_idx;
  logic                      any_req;
  logic [N_REQ-1:0][15:0]    a_lane, b_lane;
  logic [15:0]               op_a, op_b;
  logic                      op_a_err, op_b_err;
  logic [CW-1:0]             cnt;
  logic                      cnt_max;
  logic                      load_a, load_b;
  logic [15:0]               a_src;
  logic                      a_err_src;
  logic [N_REQ-1:0]          owner_oh;

  // Split the flat operand buses into per-requester lanes
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[16*i +: 16];
    assign b_lane[i] = req_b[16*i +: 16];
  end

  assign any_req = |req_valid;
  assign cnt_max = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: first asserted requester after last_grant
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_idx = last_grant;
    for (int k = 1; k <= N_REQ; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % N_REQ;
      if (!found && req_valid[cand]) begin
        gnt_idx = LW'(cand);
        found   = 1'b1;
      end
    end
  end

  // Grant decode and owner one-hot; no accept while reset is asserted
  always_comb begin
    req_ready = '0;
    owner_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state == S_IDLE) && !rst && any_req && (int'(gnt_idx) == i);
      owner_oh[i]  = (int'(last_grant) == i);
    end
  end

  // Beat-load decisions; A comes straight off the bus on the grant edge
  always_comb begin
    a_src     = op_a;
    a_err_src = op_a_err;
    if (state == S_IDLE) begin
      a_src     = a_lane[gnt_idx];
      a_err_src = req_a_parity_err[gnt_idx];
    end
    load_a = !mul_busy_out &&
             (((state == S_IDLE) && any_req) ||
              ((state == S_SEND_A) && !mul_data_in_valid));
    load_b = !mul_busy_out &&
             ((state == S_GAP) ||
              ((state == S_SEND_B) && !mul_data_in_valid));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic; a SEND state is left once its beat is on the wire
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:     if (any_req) nstate = S_SEND_A;
      S_SEND_A:   if (mul_data_in_valid) nstate = S_GAP;
      S_GAP:      nstate = S_SEND_B;
      S_SEND_B:   if (mul_data_in_valid) nstate = S_WAIT_RES;
      S_WAIT_RES: if (mul_data_out_valid || cnt_max) nstate = S_RESP;
      S_RESP:     nstate = S_IDLE;
      default:    nstate = S_IDLE;
    endcase
  end

  // Grant bookkeeping and operand capture on the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LW'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_a_err   <= 1'b0;
      op_b_err   <= 1'b0;
    end else if ((state == S_IDLE) && any_req) begin
      last_grant <= gnt_idx;
      op_a       <= a_lane[gnt_idx];
      op_b       <= b_lane[gnt_idx];
      op_a_err   <= req_a_parity_err[gnt_idx];
      op_b_err   <= req_b_parity_err[gnt_idx];
    end
  end

  // Registered multiplier input beats; data/parity hold between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_data_in        <= '0;
      mul_data_in_parity <= 1'b0;
      mul_data_in_valid  <= 1'b0;
    end else begin
      mul_data_in_valid <= 1'b0;
      if (load_a) begin
        mul_data_in        <= a_src;
        mul_data_in_parity <= (^a_src) ^ a_err_src;
        mul_data_in_valid  <= 1'b1;
      end else if (load_b) begin
        mul_data_in        <= op_b;
        mul_data_in_parity <= (^op_b) ^ op_b_err;
        mul_data_in_valid  <= 1'b1;
      end
    end
  end

  // Timeout counter: cleared leaving SEND_B, counts idle WAIT_RES cycles
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((state == S_SEND_B) && mul_data_in_valid)
      cnt <= '0;
    else if ((state == S_WAIT_RES) && !mul_data_out_valid && !cnt_max)
      cnt <= cnt + 1'b1;
  end

  // Response capture (result beats a same-cycle timeout) and owner pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_parity  <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (state == S_WAIT_RES) begin
        if (mul_data_out_valid) begin
          rsp_data    <= mul_data_out;
          rsp_parity  <= mul_data_out_parity;
          rsp_err     <= mul_data_in_parity_error;
          rsp_timeout <= 1'b0;
        end else if (cnt_max) begin
          rsp_data    <= '0;
          rsp_parity  <= 1'b0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b1;
        end
      end
      if (state == S_RESP) rsp_valid <= owner_oh;
    end
  end

endmodule

// File: tb/tb_fifomult2024_arbiter.sv
// Directed bench for fifomult2024_arbiter (N_REQ=2, TIMEOUT_CYCLES=64).
module tb_fifomult2024_arbiter;

  localparam int N  = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]  req_a_parity_err, req_b_parity_err;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_parity, rsp_err, rsp_timeout;
  logic [15:0]   mul_data_in;
  logic          mul_data_in_parity, mul_data_in_valid;
  logic          mul_busy_out;
  logic [31:0]   mul_data_out;
  logic          mul_data_out_parity, mul_data_out_valid, mul_data_in_parity_error;

  int n_chk  = 0;
  int n_fail = 0;

  fifomult2024_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_a_parity_err(req_a_parity_err), .req_b_parity_err(req_b_parity_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_parity(rsp_parity),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .mul_data_in(mul_data_in), .mul_data_in_parity(mul_data_in_parity),
    .mul_data_in_valid(mul_data_in_valid), .mul_busy_out(mul_busy_out),
    .mul_data_out(mul_data_out), .mul_data_out_parity(mul_data_out_parity),
    .mul_data_out_valid(mul_data_out_valid),
    .mul_data_in_parity_error(mul_data_in_parity_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle; ends in the response-pulse cycle.
  // d = idle WAIT_RES cycles before the result strobe; d >= TO means none.
  task automatic do_op(input int g, input logic [15:0] ea, input logic epa,
                       input logic [15:0] eb, input logic epb, input int busy_n,
                       input bit drop, input int d, input logic [31:0] res,
                       input logic rpar, input logic rerr);
    logic [N-1:0] oh;
    logic         quiet;
    oh    = 2'b01 << g;
    quiet = 1'b0;
    chk("grant", 32'(req_ready), 32'(oh));
    mul_busy_out = (busy_n > 0);
    step();
    if (drop) req_valid = '0;
    for (int k = 0; k < busy_n; k++) begin
      chk("busy_hold", 32'(mul_data_in_valid), 0);
      mul_busy_out = (k + 1 < busy_n);
      step();
    end
    chk("a_vld", 32'(mul_data_in_valid), 1);
    chk("a_data", 32'(mul_data_in), 32'(ea));
    chk("a_par", 32'(mul_data_in_parity), 32'(epa));
    step();
    chk("gap_vld", 32'(mul_data_in_valid), 0);
    chk("rsp_quiet_gap", 32'(rsp_valid), 0);
    // stray result strobe outside WAIT_RES must be ignored
    mul_data_out_valid = 1'b1;
    mul_data_out = 32'hDEADBEEF;
    mul_data_in_parity_error = 1'b1;
    step();
    mul_data_out_valid = 1'b0;
    mul_data_in_parity_error = 1'b0;
    chk("b_vld", 32'(mul_data_in_valid), 1);
    chk("b_data", 32'(mul_data_in), 32'(eb));
    chk("b_par", 32'(mul_data_in_parity), 32'(epb));
    step();
    chk("hold_data", 32'(mul_data_in), 32'(eb));
    if (d < TO) begin
      for (int k = 0; k < d; k++) begin
        quiet |= |rsp_valid;
        step();
      end
      mul_data_out_valid = 1'b1;
      mul_data_out = res;
      mul_data_out_parity = rpar;
      mul_data_in_parity_error = rerr;
      step();
      mul_data_out_valid = 1'b0;
      mul_data_in_parity_error = 1'b0;
      quiet |= |rsp_valid;
      chk("rsp_quiet", 32'(quiet), 0);
      step();
      chk("rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_data", rsp_data, res);
      chk("rsp_par", 32'(rsp_parity), 32'(rpar));
      chk("rsp_err", 32'(rsp_err), 32'(rerr));
      chk("rsp_to", 32'(rsp_timeout), 0);
    end else begin
      for (int k = 0; k < TO; k++) begin
        quiet |= |rsp_valid;
        step();
      end
      quiet |= |rsp_valid;
      chk("to_quiet", 32'(quiet), 0);
      step();
      chk("to_valid", 32'(rsp_valid), 32'(oh));
      chk("to_data", rsp_data, 0);
      chk("to_err", 32'(rsp_err), 0);
      chk("to_flag", 32'(rsp_timeout), 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    req_a_parity_err = '0; req_b_parity_err = '0;
    mul_busy_out = 1'b0; mul_data_out = '0; mul_data_out_parity = 1'b0;
    mul_data_out_valid = 1'b0; mul_data_in_parity_error = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_par", 32'(rsp_parity), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_to", 32'(rsp_timeout), 0);
    chk("rst_mul_data", 32'(mul_data_in), 0);
    chk("rst_mul_par", 32'(mul_data_in_parity), 0);
    chk("rst_mul_vld", 32'(mul_data_in_valid), 0);

    // basic: req0 3 * -2
    req_a = {16'h0000, 16'h0003};
    req_b = {16'h0000, 16'hFFFE};
    req_valid = 2'b01; #1;
    do_op(0, 16'h0003, 1'b0, 16'hFFFE, 1'b1, 0, 1, 0, 32'hFFFFFFFA, 1'b1, 1'b0);

    // fairness: both held valid after reset -> 0, 1, 0
    rst = 1'b1; step(); rst = 1'b0;
    req_a = {16'hFFFF, 16'h0005};
    req_b = {16'h0002, 16'h0007};
    req_valid = 2'b11; #1;
    do_op(0, 16'h0005, 1'b0, 16'h0007, 1'b1, 0, 0, 2, 32'd35, 1'b1, 1'b0);
    do_op(1, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 0, 0, 1, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op(0, 16'h0005, 1'b0, 16'h0007, 1'b1, 0, 0, 3, 32'd35, 1'b0, 1'b0);
    req_valid = '0; #1;

    // busy held 5 cycles starting at the grant
    req_a = {16'h0000, 16'h0010};
    req_b = {16'h0000, 16'h0100};
    req_valid = 2'b01; #1;
    do_op(0, 16'h0010, 1'b1, 16'h0100, 1'b1, 5, 1, 0, 32'h00001000, 1'b0, 1'b0);

    // req1 with injected A parity error
    req_a = {16'h0001, 16'h0000};
    req_b = {16'h0003, 16'h0000};
    req_a_parity_err = 2'b10;
    req_valid = 2'b10; #1;
    do_op(1, 16'h0001, 1'b0, 16'h0003, 1'b0, 0, 1, 1, 32'h00000003, 1'b0, 1'b1);
    req_a_parity_err = '0;

    // reset during GAP, req0 still pending
    req_a = {16'h0000, 16'h0007};
    req_b = {16'h0000, 16'h0009};
    req_valid = 2'b01; #1;
    chk("pre_rst_grant", 32'(req_ready), 32'h1);
    step();
    chk("pre_rst_a_vld", 32'(mul_data_in_valid), 1);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_mul_data", 32'(mul_data_in), 0);
    chk("mid_rst_mul_par", 32'(mul_data_in_parity), 0);
    chk("mid_rst_mul_vld", 32'(mul_data_in_valid), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 0);
    rst = 1'b0; #1;
    do_op(0, 16'h0007, 1'b1, 16'h0009, 1'b0, 0, 1, 0, 32'd63, 1'b0, 1'b0);

    // timeout: no result strobe at all
    req_a = {16'h0000, 16'h00FF};
    req_b = {16'h0000, 16'h8000};
    req_valid = 2'b01; #1;
    do_op(0, 16'h00FF, 1'b0, 16'h8000, 1'b1, 0, 1, TO, 32'h0, 1'b0, 1'b0);

    // result in the expiry cycle wins over the timeout
    req_a = {16'h0000, 16'h0003};
    req_b = {16'h0000, 16'h0003};
    req_valid = 2'b01; #1;
    do_op(0, 16'h0003, 1'b0, 16'h0003, 1'b0, 0, 1, TO - 1, 32'd9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
